// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    localparam int unsigned DefaultNreq  = 4;
    localparam int unsigned DefaultDw    = 8;
    localparam int unsigned DefaultBurst = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: first asserted request searching upward
// from last_id+1, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IdW-1:0]  last_id,
    output logic [IdW-1:0]  gnt_id,
    output logic            any
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        gnt_id = '0;
        any    = 1'b0;
        // k = NREQ wraps back to last_id itself, so it is searched last
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_id) + k) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NREQ requesters with round-robin grants of
// up to BURST words each and a one-cycle arbitration bubble between grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DefaultNreq,
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned BURST = DefaultBurst,
    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              winc,
    output logic [DW-1:0]     wdata,
    input  logic              wfull,
    output logic              gnt_valid,
    output logic [IdW-1:0]    gnt_id,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned BW = $clog2(BURST + 1);

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] gnt_id_q, gnt_id_d;
    logic [IdW-1:0] last_id_q, last_id_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [15:0]    stall_q, stall_d;

    logic [IdW-1:0] pick_id;
    logic           pick_any;
    logic           cur_valid;
    logic [DW-1:0]  cur_data;
    logic           xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .last_id (last_id_q),
        .gnt_id  (pick_id),
        .any     (pick_any)
    );

    always_comb begin
        cur_valid = req_valid[gnt_id_q];
        cur_data  = req_data[32'(gnt_id_q) * DW +: DW];
        xfer      = (state_q == GRANT) && cur_valid && !wfull;

        winc      = xfer;
        req_ready = NREQ'(xfer) << gnt_id_q;
        wdata     = (state_q == GRANT) ? cur_data : '0;
        gnt_valid = (state_q == GRANT);
        gnt_id    = gnt_id_q;
        stall_cnt = stall_q;
    end

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        beat_d    = beat_q;
        stall_d   = stall_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_id_d = pick_id;
                    beat_d   = '0;
                end
            end
            GRANT: begin
                if (wfull && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
                // Burst end and valid drop share one exit path
                if ((xfer && ((beat_q + 1'b1) == BW'(BURST))) || !cur_valid) begin
                    state_d   = IDLE;
                    last_id_d = gnt_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            last_id_q <= IdW'(NREQ - 1);
            beat_q    <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            beat_q    <= beat_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: per-requester word queues feed the DUT, a scoreboard holds
// the expected {id, word} write order, and per-cycle winc/gnt_valid traces.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned BURST = 4;
    localparam int unsigned IdW   = 2;

    logic              wclk = 1'b0;
    logic              wrst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic              wfull = 1'b0;
    logic              gnt_valid;
    logic [IdW-1:0]    gnt_id;
    logic [15:0]       stall_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DW-1:0] src [NREQ][$];
    logic [15:0]   exp_q [$];
    logic [63:0]   tr, gtr;

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (src[i].size() != 0);
            req_data[i*DW +: DW] = (src[i].size() != 0) ? src[i][0] : '0;
        end
    endtask

    task automatic load(input int id, input int n, input logic [DW-1:0] base, input bit push);
        for (int k = 0; k < n; k++) begin
            src[id].push_back(base + DW'(k));
            if (push) exp_q.push_back({8'(id), base + DW'(k)});
        end
    endtask

    task automatic expect_words(input int id, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) exp_q.push_back({8'(id), base + DW'(k)});
    endtask

    // One clock: drive, sample on the falling edge, retire accepted words.
    task automatic cycle();
        logic [NREQ-1:0] rdy;
        apply_inputs();
        @(negedge wclk);
        if (winc) begin
            chk("ready_onehot", 64'(req_ready), 64'(NREQ'(1) << gnt_id));
            if (exp_q.size() == 0) chk("unexpected_winc", 64'(1), 64'(0));
            else chk("wdata_order", 64'({8'(gnt_id), wdata}), 64'(exp_q.pop_front()));
        end else begin
            chk("ready_idle", 64'(req_ready), 64'(0));
        end
        tr  = {tr[62:0], winc};
        gtr = {gtr[62:0], gnt_valid};
        rdy = req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (rdy[i] && src[i].size() != 0) void'(src[i].pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic rst_dut();
        for (int i = 0; i < NREQ; i++) src[i].delete();
        exp_q.delete();
        wfull = 1'b0;
        wrst  = 1'b1;
        apply_inputs();
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        tr   = '0;
        gtr  = '0;
    endtask

    initial begin
        tr  = '0;
        gtr = '0;
        @(posedge wclk);
        #1;
        chk("rst_gnt_valid", 64'(gnt_valid), 64'(0));
        chk("rst_gnt_id", 64'(gnt_id), 64'(0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        chk("rst_winc", 64'(winc), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        rst_dut();

        // Req0 with 6 words: 4-beat burst, bubble, regrant for 2
        load(0, 6, 8'hA0, 1'b1);
        run(10);
        chk("A_winc_trace", tr, 64'(10'b0111101100));
        chk("A_gnt_trace", gtr, 64'(10'b0111101110));
        chk("A_drained", 64'(exp_q.size()), 64'(0));
        chk("A_gnt_id_held", 64'(gnt_id), 64'(0));

        // All four requesters busy: grants 0,1,2,3,0 of 4 beats each
        rst_dut();
        for (int i = 0; i < NREQ; i++) load(i, 8, 8'(i * 16), 1'b0);
        for (int i = 0; i < NREQ; i++) expect_words(i, 4, 8'(i * 16));
        expect_words(0, 4, 8'h04);
        run(25);
        chk("B_winc_trace", tr, 64'({5{5'b01111}}));
        chk("B_gnt_trace", gtr, 64'({5{5'b01111}}));
        chk("B_drained", 64'(exp_q.size()), 64'(0));

        // Req2 stalled by wfull for 5 cycles mid-burst
        rst_dut();
        load(2, 6, 8'h20, 1'b1);
        run(3);
        wfull = 1'b1;
        run(5);
        chk("C_stall_cnt", 64'(stall_cnt), 64'(5));
        chk("C_gnt_held", 64'(gnt_valid), 64'(1));
        chk("C_gnt_id", 64'(gnt_id), 64'(2));
        wfull = 1'b0;
        run(7);
        chk("C_winc_trace", tr, 64'(15'b011000001101100));
        chk("C_gnt_trace", gtr, 64'(15'b011111111101110));
        chk("C_stall_final", 64'(stall_cnt), 64'(5));
        chk("C_drained", 64'(exp_q.size()), 64'(0));

        // Req1 drops after 2 beats; req3 then wins over req0
        rst_dut();
        load(1, 2, 8'h10, 1'b1);
        run(4);
        load(3, 2, 8'h30, 1'b1);
        load(0, 2, 8'h00, 1'b1);
        run(9);
        chk("D_winc_trace", tr, 64'(13'b0110011001100));
        chk("D_gnt_trace", gtr, 64'(13'b0111011101110));
        chk("D_drained", 64'(exp_q.size()), 64'(0));
        chk("D_gnt_id_held", 64'(gnt_id), 64'(0));

        // Reset during beat 2 of req3
        rst_dut();
        load(3, 6, 8'h60, 1'b0);
        expect_words(3, 1, 8'h60);
        cycle();
        wfull = 1'b1;
        cycle();
        wfull = 1'b0;
        cycle();
        chk("E_stall_pre", 64'(stall_cnt), 64'(1));
        chk("E_gnt_pre", 64'({gnt_valid, 8'(gnt_id)}), 64'({1'b1, 8'd3}));
        apply_inputs();
        wrst = 1'b1;
        #1;
        chk("E_rst_winc", 64'(winc), 64'(0));
        chk("E_rst_ready", 64'(req_ready), 64'(0));
        chk("E_rst_gnt_valid", 64'(gnt_valid), 64'(0));
        chk("E_rst_gnt_id", 64'(gnt_id), 64'(0));
        chk("E_rst_stall", 64'(stall_cnt), 64'(0));
        chk("E_drained_pre", 64'(exp_q.size()), 64'(0));
        rst_dut();
        load(0, 2, 8'h70, 1'b1);
        load(3, 2, 8'h80, 1'b1);
        run(9);
        chk("E_winc_trace", tr, 64'(9'b011001100));
        chk("E_gnt_trace", gtr, 64'(9'b011101110));
        chk("E_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing one FIFO write port.
REQ-002 Parameter DW, default 8, data word width.
REQ-003 Parameter BURST, default 4, maximum words per grant.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 wclk  input  1  write-domain clock, all state on rising edge.
REQ-006 wrst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  NREQ  per-requester word-valid.
REQ-008 req_data  input  NREQ*DW  per-requester word, requester i at bits [i*DW +: DW].
REQ-009 req_ready  output  NREQ  per-requester word accepted this cycle.
REQ-010 winc  output  1  write strobe to FIFO write side.
REQ-011 wdata  output  DW  word to FIFO write side.
REQ-012 wfull  input  1  FIFO full flag, registered by FIFO.
REQ-013 gnt_valid  output  1  a requester currently holds the grant.
REQ-014 gnt_id  output  clog2(NREQ)  index of granted requester.
REQ-015 stall_cnt  output  16  saturating count of cycles with grant held and wfull high.

Function
REQ-016 The block SHALL implement states IDLE and GRANT.
REQ-017 IDLE: on any req_valid, go to GRANT with gnt_id = first valid index searching upward from last_id+1 modulo NREQ; otherwise stay.
REQ-018 Transfer SHALL occur when state==GRANT, req_valid[gnt_id]=1 and wfull=0.
REQ-019 req_ready[gnt_id] SHALL equal the transfer condition; all other req_ready bits 0.
REQ-020 winc SHALL equal the transfer condition combinationally (zero latency); wdata = req_data word of gnt_id while GRANT, 0 in IDLE.
REQ-021 beat counter (clog2(BURST+1) bits) SHALL clear on entry to GRANT and increment per transfer.
REQ-022 GRANT -> IDLE when a transfer makes the beat count equal BURST, or when req_valid[gnt_id]=0; last_id <= gnt_id on exit.
REQ-023 wfull high in GRANT: no transfer, beat count holds, grant held indefinitely, stall_cnt increments (saturates at 0xFFFF).
REQ-024 Exactly one IDLE cycle SHALL separate consecutive grants (arbitration bubble).
REQ-025 Valid drop and burst completion in the same cycle SHALL produce one exit, not two.
REQ-026 gnt_valid = (state==GRANT); gnt_id holds its last value in IDLE.
REQ-027 Words from one requester SHALL reach the FIFO in order, never interleaved within a grant.

Reset
REQ-028 On wrst high: state=IDLE, beat count=0, last_id=NREQ-1, gnt_id=0, stall_cnt=0; winc, req_ready, gnt_valid = 0 while wrst is high.
REQ-029 Reset mid-burst SHALL abandon the grant with no further transfer; first grant after release goes to lowest valid index from 0.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default NREQ/DW/BURST constants.
REQ-031 Sub-module rr_arbiter (combinational rotate-priority pick: req vector + last_id -> grant index + any) SHALL be instantiated once.

Verification
REQ-032 Req0 valid with 6 words, wfull=0 -> 4 winc beats, 1 IDLE cycle, regrant req0, 2 beats, data order preserved.
REQ-033 Req0..3 all valid continuously -> grant order 0,1,2,3,0, each 4 beats, one bubble cycle between grants.
REQ-034 Req2 granted, wfull high 5 cycles mid-burst -> winc=0 and req_ready=0 for 5 cycles, stall_cnt +5, burst resumes at the same beat count.
REQ-035 Req1 drops valid after 2 beats -> exit to IDLE, last_id=1, next valid req3 granted before req0.
REQ-036 wrst pulsed during beat 2 of req3 -> all outputs 0 immediately, stall_cnt=0; after release req0 and req3 valid -> req0 granted first.
